// File: rtl/elapsed_up_timer_if.sv
// Control and status bundle for elapsed_up_timer: start/pause/target in, count and flags out.
// The timer (slave) registers every status output; there is no backpressure.
interface elapsed_up_timer_if #(
    parameter int W = 14
);
    logic         start;
    logic         pause;
    logic [W-1:0] target;
    logic [W-1:0] elapsed;
    logic [W-1:0] remaining;
    logic         running;
    logic         paused;
    logic         done;
    logic         done_pulse;
    logic         warn;

    modport master (
        output start, pause, target,
        input  elapsed, remaining, running, paused, done, done_pulse, warn
    );

    modport slave (
        input  start, pause, target,
        output elapsed, remaining, running, paused, done, done_pulse, warn
    );
endinterface

// File: rtl/elapsed_up_timer.sv
// Up-counting game timer: a prescaler turns CLOCK_50 edges into ticks, and the timer counts to a latched target, then holds.
// Outputs come from registers one edge after the inputs are sampled; there is no backpressure.
module elapsed_up_timer #(
    parameter int TICK_DIV   = 50000,
    parameter int MAX_TICKS  = 10000,
    parameter int WARN_TICKS = 2000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    elapsed_up_timer_if.slave  bus
);
    localparam int W = $clog2(MAX_TICKS + 1);
    localparam int P = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] MAX_Q    = W'(MAX_TICKS);
    localparam logic [P-1:0] PRE_LAST = P'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_elapsed;
    logic [P-1:0]   r_presc;
    logic [W-1:0]   r_target_q;
    logic           r_done_pulse;

    state_t         w_state_nxt;
    logic [W-1:0]   w_elapsed_nxt;
    logic [P-1:0]   w_presc_nxt;
    logic [W-1:0]   w_target_nxt;
    logic           w_done_pulse_nxt;

    logic [W-1:0]   w_target_clamped;
    logic [W-1:0]   w_elapsed_inc;
    logic [W-1:0]   w_remaining;
    logic           w_tick;
    logic           w_counting;

    assign w_target_clamped = (bus.target > MAX_Q) ? MAX_Q : bus.target;
    assign w_elapsed_inc    = r_elapsed + 1'b1;
    assign w_tick           = (r_presc == PRE_LAST);
    assign w_remaining      = r_target_q - r_elapsed;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_elapsed    <= '0;
            r_presc      <= '0;
            r_target_q   <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_elapsed    <= w_elapsed_nxt;
            r_presc      <= w_presc_nxt;
            r_target_q   <= w_target_nxt;
            r_done_pulse <= w_done_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_elapsed_nxt    = r_elapsed;
        w_presc_nxt      = r_presc;
        w_target_nxt     = r_target_q;
        w_done_pulse_nxt = 1'b0;

        if (bus.start) begin
            // A zero target completes immediately and still announces completion.
            w_target_nxt     = w_target_clamped;
            w_elapsed_nxt    = '0;
            w_presc_nxt      = '0;
            w_state_nxt      = (w_target_clamped == '0) ? S_DONE : S_RUN;
            w_done_pulse_nxt = (w_target_clamped == '0);
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_tick) begin
                        w_presc_nxt   = '0;
                        w_elapsed_nxt = w_elapsed_inc;
                        if (w_elapsed_inc == r_target_q) begin
                            w_state_nxt      = S_DONE;
                            w_done_pulse_nxt = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
                // Resume edge does not count; partial prescaler progress is kept.
                S_PAUSE: begin
                    if (!bus.pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_counting     = (r_state == S_RUN) || (r_state == S_PAUSE);

    assign bus.elapsed    = r_elapsed;
    assign bus.remaining  = w_remaining;
    assign bus.running    = (r_state == S_RUN);
    assign bus.paused     = (r_state == S_PAUSE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.done_pulse = r_done_pulse;
    assign bus.warn       = w_counting && (int'(w_remaining) <= WARN_TICKS) && (w_remaining != '0);

    a_no_overrun: assert property (@(posedge CLOCK_50) disable iff (reset)
        r_elapsed <= r_target_q);

endmodule

// File: tb/tb_elapsed_up_timer.sv
// Bench for elapsed_up_timer: directed scenarios with literal expectations, then random start/pause/reset traffic,
// all checked every cycle against a tick-count model of the timer.
module tb_elapsed_up_timer;
    localparam int TD = 4;
    localparam int MX = 10;
    localparam int WN = 3;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elapsed_up_timer_if #(.W(W)) bus ();

    elapsed_up_timer #(
        .TICK_DIV   (TD),
        .MAX_TICKS  (MX),
        .WARN_TICKS (WN)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: elapsed is simply counting edges divided by TICK_DIV.
    bit m_valid = 0;
    int m_tq    = 0;
    int m_prog  = 0;
    bit m_run   = 0;
    bit m_pau   = 0;
    bit m_done  = 0;
    bit m_pulse = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int t;
        if (rst) begin
            m_valid = 1; m_tq = 0; m_prog = 0;
            m_run = 0; m_pau = 0; m_done = 0; m_pulse = 0;
        end else if (m_valid) begin
            if (bus.start) begin
                t      = int'(bus.target);
                m_tq   = (t > MX) ? MX : t;
                m_prog = 0;
                m_done = (m_tq == 0);
                m_run  = !m_done;
                m_pau  = 0;
                m_pulse = m_done;
            end else begin
                m_pulse = 0;
                if (m_run) begin
                    if (bus.pause) begin
                        m_run = 0; m_pau = 1;
                    end else begin
                        m_prog++;
                        if (m_prog / TD == m_tq) begin
                            m_run = 0; m_done = 1; m_pulse = 1;
                        end
                    end
                end else if (m_pau && !bus.pause) begin
                    m_pau = 0; m_run = 1;
                end
            end
        end
    endtask

    function automatic logic [12:0] model_vec();
        int e;
        int r;
        logic wrn;
        e   = m_prog / TD;
        r   = m_tq - e;
        wrn = (m_run || m_pau) && (r <= WN) && (r != 0);
        return {4'(e), 4'(r), m_run, m_pau, m_done, m_pulse, wrn};
    endfunction

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid)
            check("cycle", {19'd0, bus.elapsed, bus.remaining, bus.running, bus.paused,
                            bus.done, bus.done_pulse, bus.warn}, {19'd0, model_vec()});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int t);
        bus.start  = 1'b1;
        bus.target = 4'(t);
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; bus.target = '0;
        step(2);
        check("rst_elapsed", bus.elapsed, 0);
        check("rst_flags", {bus.running, bus.paused, bus.done, bus.done_pulse, bus.warn}, 0);
        rst = 1'b0;

        // Plain count to 5: one tick per 4 edges, completion at edge 20.
        do_start(5);
        check("t1_start_rem", bus.remaining, 5);
        check("t1_start_run", bus.running, 1);
        step(3);  check("t1_e3_elapsed", bus.elapsed, 0);
        step(1);  check("t1_e4_elapsed", bus.elapsed, 1);
        step(15); check("t1_e19_done", {bus.elapsed, bus.done}, {4'd4, 1'b0});
        step(1);  check("t1_e20_done", {bus.elapsed, bus.done, bus.done_pulse}, {4'd5, 1'b1, 1'b1});
        check("t1_model_pin", m_prog / TD, 5);
        step(1);  check("t1_pulse_once", bus.done_pulse, 0);
        step(10); check("t1_hold", {bus.elapsed, bus.remaining, bus.done}, {4'd5, 4'd0, 1'b1});

        // Pause for 7 edges at elapsed=2: the resume edge also does not count.
        do_start(5);
        step(8);  check("t2_e8_elapsed", bus.elapsed, 2);
        bus.pause = 1'b1;
        step(1);  check("t2_paused", {bus.paused, bus.running}, 2'b10);
        step(6);  check("t2_frozen", {bus.elapsed, bus.remaining}, {4'd2, 4'd3});
        bus.pause = 1'b0;
        step(12); check("t2_e27_done", {bus.elapsed, bus.done}, {4'd4, 1'b0});
        step(1);  check("t2_e28_done", {bus.done, bus.done_pulse}, 2'b11);

        // Zero target completes at once; oversize target clamps to MAX.
        rst = 1'b1; step(1); rst = 1'b0;
        do_start(0);
        check("t3_zero", {bus.elapsed, bus.done, bus.done_pulse}, {4'd0, 1'b1, 1'b1});
        step(1);  check("t3_zero_pulse", {bus.done, bus.done_pulse}, 2'b10);
        do_start(15);
        check("t3_clamp_rem", bus.remaining, 10);
        step(39); check("t3_e39", {bus.elapsed, bus.done}, {4'd9, 1'b0});
        step(1);  check("t3_e40", {bus.elapsed, bus.remaining, bus.done}, {4'd10, 4'd0, 1'b1});
        check("t3_model_pin", m_tq, 10);

        // Restart mid-run, then reset mid-run.
        do_start(5);
        step(12); check("t4_e12", bus.elapsed, 3);
        do_start(2);
        check("t4_restart", {bus.elapsed, bus.remaining, bus.running}, {4'd0, 4'd2, 1'b1});
        step(7);  check("t4_e7", bus.done, 0);
        step(1);  check("t4_e8", {bus.elapsed, bus.done, bus.done_pulse}, {4'd2, 1'b1, 1'b1});
        do_start(5);
        step(4);  check("t4_e4", bus.elapsed, 1);
        rst = 1'b1;
        step(1);
        check("t4_reset", {bus.elapsed, bus.remaining, bus.running, bus.paused,
                           bus.done, bus.done_pulse, bus.warn}, 0);
        rst = 1'b0;
        step(1);  check("t4_idle", {bus.elapsed, bus.done, bus.done_pulse}, 0);

        // Warn window: remaining 3..1 while running or paused.
        do_start(5);
        check("t5_warn_e0", bus.warn, 0);
        step(4);  check("t5_warn_e1", {bus.elapsed, bus.warn}, {4'd1, 1'b0});
        step(4);  check("t5_warn_e2", {bus.elapsed, bus.warn}, {4'd2, 1'b1});
        bus.pause = 1'b1;
        step(2);  check("t5_warn_paused", {bus.paused, bus.warn}, 2'b11);
        bus.pause = 1'b0;
        step(1);  check("t5_resume", bus.running, 1);
        step(11); check("t5_warn_e4", {bus.elapsed, bus.warn}, {4'd4, 1'b1});
        step(1);  check("t5_done_nowarn", {bus.done, bus.warn}, 2'b10);

        // Start and pause on the same edge: start wins, pause lands next edge.
        bus.start = 1'b1; bus.pause = 1'b1; bus.target = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5_start_wins", {bus.running, bus.paused}, 2'b10);
        step(1);  check("t5_pause_next", {bus.running, bus.paused}, 2'b01);
        bus.pause = 1'b0;
        step(1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.start  = ($urandom_range(0, 29) == 0);
            bus.target = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
